// File: rtl/pe2d_result_collector_if.sv
// Result path between the 2x2 PE array, the collector and its downstream consumer.
// master = producer/consumer side (array + sink), slave = collector.
interface pe2d_result_collector_if #(
   parameter int IN_W  = 64,
   parameter int OUT_W = 8
);
   logic                 i_flag;
   logic [IN_W-1:0]      i_mat;
   logic [5:0]           i_shift;
   logic                 i_clr;
   logic                 i_ready;
   logic                 o_valid;
   logic [4*OUT_W-1:0]   o_mat;
   logic                 o_ovf;
   logic                 o_frag;

   modport master (
      output i_flag, i_mat, i_shift, i_clr, i_ready,
      input  o_valid, o_mat, o_ovf, o_frag
   );

   modport slave (
      input  i_flag, i_mat, i_shift, i_clr, i_ready,
      output o_valid, o_mat, o_ovf, o_frag
   );
endinterface

// File: rtl/pe2d_result_collector.sv
// Collects the 4-word result burst of the 2x2 PE array, requantizes each word and
// hands the packed block downstream, with one pending slot behind the output register.
module pe2d_result_collector #(
   parameter int IN_W    = 64,
   parameter int OUT_W   = 8,
   parameter int RELU_EN = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   pe2d_result_collector_if.slave bus
);
   localparam longint SAT_MAX_L = (longint'(1) << (OUT_W - 1)) - 1;
   localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'(SAT_MAX_L);
   localparam logic signed [IN_W-1:0] SAT_MIN = -SAT_MAX - 1;

   logic [1:0]                cnt_q, cnt_d;
   logic                      drop_q, drop_d;
   logic                      pending_q, pending_d;
   logic [5:0]                sh_q, sh_d;
   logic [3:0][OUT_W-1:0]     stage_q, stage_d;
   logic                      valid_q, valid_d;
   logic [4*OUT_W-1:0]        mat_q, mat_d;
   logic                      ovf_q, ovf_d;
   logic                      frag_q, frag_d;

   logic [5:0]                sh_eff;
   logic signed [IN_W-1:0]    shifted, clipped;
   logic [OUT_W-1:0]          q_word;
   logic                      out_free, start, ovf_evt, cap, complete, frag_evt;

   // Word 0 uses the live shift so the whole block shares the amount sampled with it.
   assign sh_eff  = (cnt_q == 2'd0) ? bus.i_shift : sh_q;
   assign shifted = $signed(bus.i_mat) >>> sh_eff;

   always_comb begin
      clipped = shifted;
      if (RELU_EN != 0 && shifted[IN_W-1]) clipped = '0;
      if (clipped > SAT_MAX)      q_word = SAT_MAX[OUT_W-1:0];
      else if (clipped < SAT_MIN) q_word = SAT_MIN[OUT_W-1:0];
      else                        q_word = clipped[OUT_W-1:0];
   end

   // A new block may start while the pending slot drains on the same edge.
   assign out_free = !valid_q || bus.i_ready;
   assign start    = bus.i_flag && !drop_q && (cnt_q == 2'd0);
   assign ovf_evt  = start && pending_q && !out_free;
   assign cap      = bus.i_flag && !drop_q && !ovf_evt;
   assign complete = cap && (cnt_q == 2'd3);
   assign frag_evt = !bus.i_flag && (cnt_q != 2'd0);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_stage
         assign stage_d[gi] = (cap && cnt_q == 2'(gi)) ? q_word : stage_q[gi];
      end
   endgenerate

   always_comb begin
      cnt_d     = cnt_q;
      drop_d    = ovf_evt || (drop_q && bus.i_flag);
      sh_d      = (cap && cnt_q == 2'd0) ? bus.i_shift : sh_q;
      pending_d = pending_q;
      valid_d   = valid_q;
      mat_d     = mat_q;
      ovf_d     = ovf_evt  || (ovf_q  && !bus.i_clr);
      frag_d    = frag_evt || (frag_q && !bus.i_clr);

      if (cap)           cnt_d = cnt_q + 2'd1;
      else if (frag_evt) cnt_d = 2'd0;

      if (out_free) begin
         if (pending_q) begin
            mat_d     = stage_q;
            valid_d   = 1'b1;
            pending_d = complete;
         end else if (complete) begin
            mat_d   = {q_word, stage_q[2], stage_q[1], stage_q[0]};
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end else if (complete) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         drop_q    <= 1'b0;
         pending_q <= 1'b0;
         sh_q      <= '0;
         stage_q   <= '0;
         valid_q   <= 1'b0;
         mat_q     <= '0;
         ovf_q     <= 1'b0;
         frag_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         drop_q    <= drop_d;
         pending_q <= pending_d;
         sh_q      <= sh_d;
         stage_q   <= stage_d;
         valid_q   <= valid_d;
         mat_q     <= mat_d;
         ovf_q     <= ovf_d;
         frag_q    <= frag_d;
      end
   end

   assign bus.o_valid = valid_q;
   assign bus.o_mat   = mat_q;
   assign bus.o_ovf   = ovf_q;
   assign bus.o_frag  = frag_q;
endmodule

// File: tb/tb_pe2d_result_collector.sv
// Scoreboard bench: two collectors (RELU_EN=0 and 1) share one stimulus stream and
// are checked against a block-level reference model.
module tb_pe2d_result_collector;
   logic        clk = 1'b0;
   logic        rst;
   logic        flag, clr, ready;
   logic [63:0] mat;
   logic [5:0]  shift;

   always #5 clk = ~clk;

   pe2d_result_collector_if #(.IN_W(64), .OUT_W(8)) ifa ();
   pe2d_result_collector_if #(.IN_W(64), .OUT_W(8)) ifb ();

   assign ifa.i_flag = flag;  assign ifb.i_flag = flag;
   assign ifa.i_mat  = mat;   assign ifb.i_mat  = mat;
   assign ifa.i_shift = shift; assign ifb.i_shift = shift;
   assign ifa.i_clr  = clr;   assign ifb.i_clr  = clr;
   assign ifa.i_ready = ready; assign ifb.i_ready = ready;

   pe2d_result_collector #(.IN_W(64), .OUT_W(8), .RELU_EN(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   pe2d_result_collector #(.IN_W(64), .OUT_W(8), .RELU_EN(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   int checks = 0;
   int errors = 0;
   bit rnd_mode = 0;

   // reference model state
   longint      cw[$];
   int          csh = 0;
   bit          dropping = 0;
   int          held = 0;
   bit          eovf = 0, efrag = 0;
   logic [31:0] expa[$], expb[$];
   logic [31:0] last_a = '0, last_b = '0;
   int          dlv_a = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] qz(input longint w, input int sh, input bit relu);
      longint y;
      y = w >>> sh;
      if (relu && y < 0) y = 0;
      if (y > 127)  y = 127;
      if (y < -128) y = -128;
      return 8'(y);
   endfunction

   function automatic logic [31:0] pack(input longint w0, w1, w2, w3, input int sh, input bit relu);
      return {qz(w3, sh, relu), qz(w2, sh, relu), qz(w1, sh, relu), qz(w0, sh, relu)};
   endfunction

   task automatic model_step();
      bit hs, comp, ov, fr;
      if (rst) begin
         cw.delete(); expa.delete(); expb.delete();
         dropping = 0; held = 0; eovf = 0; efrag = 0; csh = 0;
         return;
      end
      hs = (held > 0) && ready;
      comp = 0; ov = 0; fr = 0;
      if (flag) begin
         if (!dropping) begin
            if (cw.size() == 0) begin
               if (held == 2 && !ready) begin
                  dropping = 1; ov = 1;
               end else begin
                  csh = int'(shift);
                  cw.push_back($signed(mat));
               end
            end else begin
               cw.push_back($signed(mat));
            end
            if (cw.size() == 4) begin
               expa.push_back(pack(cw[0], cw[1], cw[2], cw[3], csh, 1'b0));
               expb.push_back(pack(cw[0], cw[1], cw[2], cw[3], csh, 1'b1));
               cw.delete();
               comp = 1;
            end
         end
      end else begin
         dropping = 0;
         if (cw.size() != 0) begin
            fr = 1;
            cw.delete();
         end
      end
      if (clr) begin eovf = 0; efrag = 0; end
      if (ov) eovf = 1;
      if (fr) efrag = 1;
      held = held - int'(hs) + int'(comp);
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   task automatic mon(input int id, input logic v, input logic [31:0] m, input logic ov, input logic fr);
      logic [31:0] e;
      int qs;
      chk($sformatf("o_valid[%0d]", id), 64'(v), 64'(held > 0));
      chk($sformatf("o_ovf[%0d]", id), 64'(ov), 64'(eovf));
      chk($sformatf("o_frag[%0d]", id), 64'(fr), 64'(efrag));
      if (v === 1'b1) begin
         qs = (id == 0) ? expa.size() : expb.size();
         if (qs == 0) begin
            checks++; errors++;
            $display("FAIL o_mat[%0d]: got %h with no block expected", id, m);
         end else begin
            e = (id == 0) ? expa[0] : expb[0];
            chk($sformatf("o_mat[%0d]", id), 64'(m), 64'(e));
            if (ready) begin
               if (id == 0) begin
                  void'(expa.pop_front()); last_a = m; dlv_a++;
               end else begin
                  void'(expb.pop_front()); last_b = m;
               end
            end
         end
      end
   endtask

   initial forever begin
      @(negedge clk);
      mon(0, ifa.o_valid, ifa.o_mat, ifa.o_ovf, ifa.o_frag);
      mon(1, ifb.o_valid, ifb.o_mat, ifb.o_ovf, ifb.o_frag);
   end

   task automatic tick();
      if (rnd_mode) begin
         ready = ($urandom_range(0, 3) != 0);
         clr   = ($urandom_range(0, 15) == 0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input longint w0, w1, w2, w3, input int n, input int sh);
      longint w[4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int i = 0; i < n; i++) begin
         flag  = 1'b1;
         mat   = w[i];
         shift = (i == 0) ? 6'(sh) : 6'($urandom);
         tick();
      end
      flag = 1'b0;
      mat  = {$urandom, $urandom};
   endtask

   function automatic longint rnd_word();
      case ($urandom_range(0, 3))
         0:       return longint'($urandom_range(0, 600)) - 300;
         1:       return longint'($urandom_range(0, 32'h20000)) - 32'h10000;
         2:       return $signed({$urandom, $urandom});
         default: return ($urandom_range(0, 1) != 0) ? 64'sh7fff_ffff_ffff_ffff : 64'sh8000_0000_0000_0000;
      endcase
   endfunction

   task automatic chk_outputs_zero(input string tag);
      chk({tag, " a.valid"}, 64'(ifa.o_valid), 64'd0);
      chk({tag, " a.mat"},   64'(ifa.o_mat),   64'd0);
      chk({tag, " a.ovf"},   64'(ifa.o_ovf),   64'd0);
      chk({tag, " a.frag"},  64'(ifa.o_frag),  64'd0);
      chk({tag, " b.valid"}, 64'(ifb.o_valid), 64'd0);
      chk({tag, " b.mat"},   64'(ifb.o_mat),   64'd0);
   endtask

   initial begin
      int n, gap, d0;
      rst = 1'b1; flag = 1'b0; clr = 1'b0; ready = 1'b1; mat = '0; shift = '0;
      tick(); tick();
      chk_outputs_zero("reset");
      rst = 1'b0;
      tick();

      // basic
      send(1, 2, 3, 4, 4, 0);
      repeat (3) tick();
      chk("basic a", 64'(last_a), 64'h0403_0201);
      $display("basic block: a=%h b=%h", last_a, last_b);

      // shift and saturation
      send(64'sh1000, -64'sh1000, 64'sh50, -64'sh58, 4, 4);
      repeat (3) tick();
      chk("shift a", 64'(last_a), 64'hFA05_807F);
      chk("shift b", 64'(last_b), 64'h0005_007F);
      $display("shift block: a=%h b=%h", last_a, last_b);

      // relu
      send(-5, 7, -1, 0, 4, 0);
      repeat (3) tick();
      chk("relu b", 64'(last_b), 64'h0000_0700);
      chk("relu a", 64'(last_a), 64'h00FF_07FB);
      $display("relu block: a=%h b=%h", last_a, last_b);

      // backpressure and overflow
      ready = 1'b0;
      d0 = dlv_a;
      send(1, 2, 3, 4, 4, 0); tick();
      send(5, 6, 7, 8, 4, 0); tick();
      send(9, 10, 11, 12, 4, 0); tick();
      chk("ovf set", 64'(ifa.o_ovf), 64'd1);
      chk("held a", 64'(ifa.o_mat), 64'h0403_0201);
      ready = 1'b1;
      repeat (4) tick();
      chk("ovf deliveries", 64'(dlv_a - d0), 64'd2);
      chk("ovf last", 64'(last_a), 64'h0807_0605);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("ovf clr", 64'(ifa.o_ovf), 64'd0);
      $display("overflow: delivered %0d blocks, last=%h", dlv_a - d0, last_a);

      // fragment
      d0 = dlv_a;
      send(9, 9, 0, 0, 2, 0); tick();
      send(1, 2, 3, 4, 4, 0);
      repeat (3) tick();
      chk("frag set", 64'(ifa.o_frag), 64'd1);
      chk("frag deliveries", 64'(dlv_a - d0), 64'd1);
      chk("frag block", 64'(last_a), 64'h0403_0201);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("frag clr", 64'(ifa.o_frag), 64'd0);
      $display("fragment: delivered %0d blocks, last=%h", dlv_a - d0, last_a);

      // reset mid-burst
      ready = 1'b0;
      send(1, 2, 3, 4, 4, 0); tick();
      chk("pre-reset valid", 64'(ifa.o_valid), 64'd1);
      send(21, 22, 0, 0, 2, 0);
      rst = 1'b1;
      #1;
      chk_outputs_zero("midreset");
      tick();
      rst = 1'b0; ready = 1'b1;
      tick();
      send(5, 6, 7, 8, 4, 0);
      repeat (3) tick();
      chk("post-reset block", 64'(last_a), 64'h0807_0605);
      $display("reset mid-burst: next block=%h", last_a);

      // randomized traffic
      rnd_mode = 1;
      for (int b = 0; b < 400; b++) begin
         n   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 4;
         send(rnd_word(), rnd_word(), rnd_word(), rnd_word(), n,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6)));
         gap = (n < 4) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 2));
         repeat (gap) tick();
      end
      rnd_mode = 0;
      flag = 1'b0; ready = 1'b1; clr = 1'b0;
      repeat (6) tick();
      chk("drain a", 64'(expa.size()), 64'd0);
      chk("drain b", 64'(expb.size()), 64'd0);
      $display("random phase: total deliveries on a=%0d", dlv_a);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
